// File: rtl/mil_mem_stream_encoder.sv
// MIL-word to memory-stream encoder: typed words are queued in a small FIFO with a one-entry
// skid, then pushed out one word at a time, with an escape word in front when one is needed.
module mil_mem_stream_encoder #(
    parameter int unsigned      DATAW      = 16,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [DATAW-3:0] ESC_PREFIX = 14'h3FE8,
    parameter bit               ESC_ALL    = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mil_request,
    input  logic [1:0]                   mil_type,
    input  logic [DATAW-1:0]             mil_data,
    output logic                         mil_done,
    output logic                         push_request,
    output logic [DATAW-1:0]             push_data,
    input  logic                         push_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         overflow
);

    localparam int unsigned LVLW = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned ENTW = DATAW + 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ESC_LOAD  = 3'd1;
    localparam logic [2:0] S_ESC_WAIT  = 3'd2;
    localparam logic [2:0] S_WORD_LOAD = 3'd3;
    localparam logic [2:0] S_WORD_WAIT = 3'd4;

    logic [ENTW-1:0]  r_mem [DEPTH];
    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [LVLW-1:0]  r_count;
    logic             r_skid_valid;
    logic [ENTW-1:0]  r_skid;
    logic             r_mil_done;
    logic             r_overflow;
    logic [2:0]       r_state;
    logic             r_push_request;
    logic [DATAW-1:0] r_push_data;
    logic [DATAW-1:0] r_hold_data;

    logic             w_pop;
    logic             w_space;
    logic             w_wr_en;
    logic [ENTW-1:0]  w_wr_entry;
    logic             w_skid_load;
    logic             w_drop;
    logic [ENTW-1:0]  w_head;
    logic [1:0]       w_head_type;
    logic [DATAW-1:0] w_head_data;
    logic             w_esc_needed;
    logic [2:0]       w_state_next;
    logic             w_push_request_next;
    logic [DATAW-1:0] w_push_data_next;
    logic [DATAW-1:0] w_hold_data_next;

    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_space      = (r_count != LVLW'(DEPTH)) || w_pop;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_type  = w_head[ENTW-1 -: 2];
    assign w_head_data  = w_head[DATAW-1:0];
    assign w_esc_needed = ESC_ALL || (w_head_type != 2'd3) || (w_head_data[DATAW-1:2] == ESC_PREFIX);

    // A parked skid word always goes ahead of anything new; new requests are dropped meanwhile.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_entry  = r_skid;
        w_skid_load = 1'b0;
        w_drop      = 1'b0;
        if (r_skid_valid) begin
            w_wr_en = w_space;
            w_drop  = mil_request;
        end else if (mil_request) begin
            if (w_space) begin
                w_wr_en    = 1'b1;
                w_wr_entry = {mil_type, mil_data};
            end else begin
                w_skid_load = 1'b1;
            end
        end
    end

    // Output sequencer next-state and registered-output values.
    always_comb begin
        w_state_next        = r_state;
        w_push_request_next = 1'b0;
        w_push_data_next    = r_push_data;
        w_hold_data_next    = r_hold_data;
        case (r_state)
            S_IDLE: begin
                w_push_data_next = '0;
                if (w_pop) begin
                    w_hold_data_next    = w_head_data;
                    w_push_request_next = 1'b1;
                    if (w_esc_needed) begin
                        w_state_next     = S_ESC_LOAD;
                        w_push_data_next = {ESC_PREFIX, w_head_type};
                    end else begin
                        w_state_next     = S_WORD_LOAD;
                        w_push_data_next = w_head_data;
                    end
                end
            end
            S_ESC_LOAD:  w_state_next = S_ESC_WAIT;
            S_ESC_WAIT: begin
                if (push_done) begin
                    w_state_next        = S_WORD_LOAD;
                    w_push_request_next = 1'b1;
                    w_push_data_next    = r_hold_data;
                end
            end
            S_WORD_LOAD: w_state_next = S_WORD_WAIT;
            S_WORD_WAIT: begin
                if (push_done) begin
                    w_state_next     = S_IDLE;
                    w_push_data_next = '0;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_push_data_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_skid_valid   <= 1'b0;
            r_skid         <= '0;
            r_mil_done     <= 1'b0;
            r_overflow     <= 1'b0;
            r_state        <= S_IDLE;
            r_push_request <= 1'b0;
            r_push_data    <= '0;
            r_hold_data    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            r_count <= r_count + LVLW'(w_wr_en) - LVLW'(w_pop);
            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid       <= {mil_type, mil_data};
            end else if (r_skid_valid && w_wr_en) begin
                r_skid_valid <= 1'b0;
            end
            r_mil_done     <= w_wr_en;
            r_overflow     <= r_overflow | w_drop;
            r_state        <= w_state_next;
            r_push_request <= w_push_request_next;
            r_push_data    <= w_push_data_next;
            r_hold_data    <= w_hold_data_next;
        end
    end

    assign mil_done     = r_mil_done;
    assign push_request = r_push_request;
    assign push_data    = r_push_data;
    assign fifo_level   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_mil_mem_stream_encoder.sv
// Bench for mil_mem_stream_encoder: directed corner cases plus a randomized run checked
// against a queue of expected stream words built from the escape rules.
module tb_mil_mem_stream_encoder;

    localparam int unsigned DATAW = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVLW  = $clog2(DEPTH + 1);

    logic             clk          = 1'b0;
    logic             rst          = 1'b1;
    logic             mil_request  = 1'b0;
    logic [1:0]       mil_type     = 2'd0;
    logic [DATAW-1:0] mil_data     = '0;
    logic             mil_done;
    logic             push_request;
    logic [DATAW-1:0] push_data;
    logic             push_done    = 1'b0;
    logic [LVLW-1:0]  fifo_level;
    logic             overflow;

    logic             mil_request2 = 1'b0;
    logic             mil_done2;
    logic             push_request2;
    logic [DATAW-1:0] push_data2;
    logic             push_done2   = 1'b0;
    logic [LVLW-1:0]  fifo_level2;
    logic             overflow2;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [15:0]      sb[$];
    bit               mon_en  = 1'b0;
    bit               sink_en = 1'b0;
    logic             prev_req = 1'b0;
    int               sink_cnt = 0;
    logic [15:0]      mon_exp;
    logic [15:0]      words[7];

    always #5 clk = ~clk;

    mil_mem_stream_encoder #(.DATAW(DATAW), .DEPTH(DEPTH), .ESC_PREFIX(14'h3FE8), .ESC_ALL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .mil_request(mil_request), .mil_type(mil_type), .mil_data(mil_data),
        .mil_done(mil_done), .push_request(push_request), .push_data(push_data), .push_done(push_done),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    mil_mem_stream_encoder #(.DATAW(DATAW), .DEPTH(DEPTH), .ESC_PREFIX(14'h3FE8), .ESC_ALL(1'b1)) u_dut_all (
        .clk(clk), .rst(rst), .mil_request(mil_request2), .mil_type(mil_type), .mil_data(mil_data),
        .mil_done(mil_done2), .push_request(push_request2), .push_data(push_data2), .push_done(push_done2),
        .fifo_level(fifo_level2), .overflow(overflow2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit needs_esc(input logic [1:0] t, input logic [15:0] d, input bit all);
        return all || (t != 2'd3) || (d >= 16'hFFA0 && d <= 16'hFFA3);
    endfunction

    task automatic model_push(input logic [1:0] t, input logic [15:0] d);
        if (needs_esc(t, d, 1'b0)) sb.push_back(16'hFFA0 + 16'(t));
        sb.push_back(d);
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] d);
        mil_type    = t;
        mil_data    = d;
        mil_request = 1'b1;
        tick();
        mil_request = 1'b0;
    endtask

    // Wait for a push strobe, compare it, then acknowledge once the DUT is waiting.
    task automatic expect_word(input string tag, input logic [15:0] exp);
        int n = 0;
        while (!push_request && n < 30) begin
            tick();
            n++;
        end
        check_eq(tag, 32'({push_request, push_data}), 32'({1'b1, exp}));
        tick();
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mil_done", 32'(mil_done), 32'(prev_req));
            prev_req = mil_request;
            if (push_request) begin
                if (sb.size() == 0) begin
                    check_eq("stream_extra", 32'(push_request), 32'(0));
                end else begin
                    mon_exp = sb.pop_front();
                    check_eq("stream", 32'(push_data), 32'(mon_exp));
                end
            end
        end
    end

    // Random-latency sink: push_done 1..3 cycles after each push strobe.
    initial begin
        forever begin
            tick();
            if (sink_en) begin
                if (sink_cnt != 0) begin
                    sink_cnt--;
                    push_done = (sink_cnt == 0);
                end else begin
                    push_done = 1'b0;
                    if (push_request) sink_cnt = $urandom_range(3, 1);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  t;
        logic [15:0] d;
        int          n;

        // Reset dominates toggling inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mil_request = 1'($urandom);
            mil_type    = 2'($urandom);
            mil_data    = 16'($urandom);
            push_done   = 1'($urandom);
            tick();
            check_eq("t1_reset_outs", 32'({mil_done, push_request, push_data, fifo_level, overflow}), 32'(0));
        end
        mil_request = 1'b0;
        push_done   = 1'b0;
        rst         = 1'b0;
        tick();

        // Plain data word: done next cycle, push two cycles after strobe.
        send(2'd3, 16'h1234);
        check_eq("t2_done", 32'({mil_done, push_request}), 32'(2'b10));
        check_eq("t2_level1", 32'(fifo_level), 32'(1));
        tick();
        check_eq("t2_done_pulse", 32'(mil_done), 32'(0));
        check_eq("t2_push", 32'({push_request, push_data}), 32'({1'b1, 16'h1234}));
        check_eq("t2_level0", 32'(fifo_level), 32'(0));
        tick();
        check_eq("t2_hold", 32'({push_request, push_data}), 32'({1'b0, 16'h1234}));
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
        check_eq("t2_idle", 32'({push_request, push_data}), 32'(0));

        // Non-data types get an escape word.
        send(2'd1, 16'h0821);
        expect_word("t3_cmd_esc", 16'hFFA1);
        expect_word("t3_cmd_word", 16'h0821);
        send(2'd2, 16'h0000);
        expect_word("t3_sts_esc", 16'hFFA2);
        expect_word("t3_sts_word", 16'h0000);

        // Colliding data word is escaped; the word just below the escape range is not.
        send(2'd3, 16'hFFA2);
        expect_word("t4_coll_esc", 16'hFFA3);
        expect_word("t4_coll_word", 16'hFFA2);
        send(2'd3, 16'hFF9F);
        expect_word("t4_edge_word", 16'hFF9F);
        repeat (3) begin
            tick();
            check_eq("t4_single", 32'({push_request, fifo_level}), 32'(0));
        end

        // ESC_ALL instance escapes plain data too.
        mil_type     = 2'd3;
        mil_data     = 16'h0001;
        mil_request2 = 1'b1;
        tick();
        mil_request2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!push_request2 && n < 30) begin
                tick();
                n++;
            end
            check_eq(k == 0 ? "t4_all_esc" : "t4_all_word", 32'({push_request2, push_data2}),
                     32'({1'b1, (k == 0) ? 16'hFFA3 : 16'h0001}));
            tick();
            push_done2 = 1'b1;
            tick();
            push_done2 = 1'b0;
        end

        // Fill FIFO with sink stalled: 5 accepted, 6th parked in skid, 7th dropped.
        for (int i = 0; i < 7; i++) begin
            words[i] = 16'($urandom_range(0, 16'hFF00));
            send(2'd3, words[i]);
            check_eq("t5_done", 32'(mil_done), 32'(i < 5));
            tick();
        end
        check_eq("t5_overflow", 32'(overflow), 32'(1));
        check_eq("t5_level_full", 32'(fifo_level), 32'(4));
        check_eq("t5_first_held", 32'({push_request, push_data}), 32'({1'b0, words[0]}));
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
        tick();
        check_eq("t5_skid_drain", 32'({mil_done, fifo_level}), 32'({1'b1, 3'd4}));
        for (int i = 1; i < 6; i++) expect_word("t5_order", words[i]);
        tick();
        check_eq("t5_end", 32'({push_request, fifo_level, overflow}), 32'({1'b0, 3'd0, 1'b1}));

        // Reset while waiting on an escape; a late push_done must be ignored.
        send(2'd1, 16'h0777);
        tick();
        check_eq("t6_esc", 32'({push_request, push_data}), 32'({1'b1, 16'hFFA1}));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_reset", 32'({mil_done, push_request, push_data, fifo_level, overflow}), 32'(0));
        tick();
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
        repeat (3) begin
            tick();
            check_eq("t6_idle", 32'({push_request, push_data, fifo_level, overflow}), 32'(0));
        end
        send(2'd3, 16'h5A5A);
        tick();
        check_eq("t6_restart", 32'({push_request, push_data}), 32'({1'b1, 16'h5A5A}));
        tick();
        push_done = 1'b1;
        tick();
        push_done = 1'b0;
        tick();

        // Randomized traffic, throttled so the FIFO never fills.
        prev_req = 1'b0;
        mon_en   = 1'b1;
        sink_en  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            n = 0;
            while (sb.size() > 2 && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check_eq("rnd_throttle", 32'(sb.size()), 32'(2));
            t = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) d = 16'hFF9E + 16'($urandom_range(7, 0));
            else                           d = 16'($urandom);
            model_push(t, d);
            send(t, d);
            repeat ($urandom_range(3, 0)) tick();
        end
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check_eq("rnd_drain", 32'(sb.size()), 32'(0));
        repeat (5) tick();
        mon_en  = 1'b0;
        sink_en = 1'b0;
        check_eq("rnd_final", 32'({fifo_level, overflow, push_request}), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
